encap_coef_sequencer: RTL and testbench

- Parametrised, self-sequencing successor to the encapsulation datapath register bank.
- Replaces externally driven hold/increment/clear strobes with an internal FSM that runs one complete coefficient pass.
- Each pass writes one header word (degree/weight) to the S memory, then streams P coefficients from source memory to destination memory through a fixed-latency read pipeline.
- Each written coefficient is selected per mode: modulo-reduced or rounded.

---
 rtl/encap_coef_sequencer.sv | 179 +++++++++++++++++
 tb/tb_encap_coef_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/encap_coef_sequencer.sv
// Self-sequencing coefficient pass: one header write to the S memory, then P
// coefficients streamed from source to destination memory through a fixed-latency read pipeline.
module encap_coef_sequencer #(
    parameter int P        = 761,
    parameter int AW       = 11,
    parameter int DW       = 13,
    parameter int SW       = 26,
    parameter int RD_LAT   = 1,
    parameter int HDR_ADDR = 2047
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] deg_in,
    input  logic [DW-1:0] mod_in,
    input  logic [DW-1:0] round_in,
    input  logic          stall,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          hdr_we,
    output logic [AW-1:0] hdr_addr,
    output logic [SW-1:0] hdr_data,
    output logic          busy,
    output logic          done
);

    generate
        if (P < 2 || (P - 1) >= (1 << AW)) begin : g_bad_p
            $error("P must be at least 2 and P-1 must fit in AW bits");
        end
        if (SW < AW) begin : g_bad_sw
            $error("SW must be at least AW");
        end
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("RD_LAT must be in 1..4");
        end
    endgenerate

    localparam logic [AW-1:0] LAST_IDX = AW'(P - 1);
    localparam logic [AW-1:0] HDR_A    = AW'(HDR_ADDR);

    typedef enum logic [2:0] {IDLE, HDR, RUN, DRAIN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] idx_reg, idx_next;
    logic [1:0]    mode_reg, mode_next;
    logic [AW-1:0] deg_reg, deg_next;

    logic [RD_LAT-1:0] vld_vec;
    logic              drain_empty;
    logic [AW-1:0]     head_addr;

    // Read pipeline: stage 0 captures the issued read, the last stage is the write head.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic          v_reg;
            logic [AW-1:0] a_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_reg <= 1'b0;
                        a_reg <= '0;
                    end else begin
                        v_reg <= rd_en;
                        a_reg <= idx_reg;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_reg <= 1'b0;
                        a_reg <= '0;
                    end else begin
                        v_reg <= g_stage[gi-1].v_reg;
                        a_reg <= g_stage[gi-1].a_reg;
                    end
                end
            end
            assign vld_vec[gi] = v_reg;
        end

        // No reads issue in DRAIN, so the pipeline is empty next cycle once every
        // stage except the head is clear.
        if (RD_LAT == 1) begin : g_drain1
            assign drain_empty = 1'b1;
        end else begin : g_drainn
            assign drain_empty = (vld_vec[RD_LAT-2:0] == '0);
        end
    endgenerate

    assign head_addr = g_stage[RD_LAT-1].a_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            mode_reg  <= '0;
            deg_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            mode_reg  <= mode_next;
            deg_reg   <= deg_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        mode_next  = mode_reg;
        deg_next   = deg_reg;
        rd_en      = 1'b0;
        rd_addr    = '0;
        hdr_we     = 1'b0;
        hdr_addr   = '0;
        hdr_data   = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mode_next  = mode;
                    deg_next   = deg_in;
                    idx_next   = '0;
                    state_next = HDR;
                end
            end
            HDR: begin
                busy       = 1'b1;
                hdr_we     = 1'b1;
                hdr_addr   = HDR_A;
                hdr_data   = SW'(deg_reg);
                state_next = mode_reg[1] ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (!stall) begin
                    rd_en   = 1'b1;
                    rd_addr = idx_reg;
                    if (idx_reg == LAST_IDX) begin
                        state_next = DRAIN;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_empty) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                idx_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write side follows the pipeline head; data comes from whichever unit the mode selects.
    always_comb begin
        wr_en   = vld_vec[RD_LAT-1];
        wr_addr = '0;
        wr_data = '0;
        if (wr_en) begin
            wr_addr = head_addr;
            wr_data = mode_reg[0] ? round_in : mod_in;
        end
    end

endmodule

// File: tb/tb_encap_coef_sequencer.sv
// Directed bench: two instances (RD_LAT 1 and 3) checked every cycle against a
// pass-level timeline model built from the event rules, plus literal pins of that model.
module tb_encap_coef_sequencer;

    localparam int P    = 761;
    localparam int NCYC = 8192;

    typedef struct packed {
        logic        rd_en;
        logic [10:0] rd_addr;
        logic        wr_en;
        logic [10:0] wr_addr;
        logic [12:0] wr_data;
        logic        hdr_we;
        logic [10:0] hdr_addr;
        logic [25:0] hdr_data;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct {
        int     id;
        longint got;
        longint want;
    } pin_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [10:0] deg_in = '0;
    logic        stall;
    int          cyc = 0;

    logic        stall_tab [NCYC];
    obs_t        exp_tab [2][NCYC];
    pin_t        pin_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    logic [12:0] mod_a, round_a, mod_b, round_b;
    logic        rd_en_a, wr_en_a, hdr_we_a, busy_a, done_a;
    logic        rd_en_b, wr_en_b, hdr_we_b, busy_b, done_b;
    logic [10:0] rd_addr_a, wr_addr_a, hdr_addr_a, rd_addr_b, wr_addr_b, hdr_addr_b;
    logic [12:0] wr_data_a, wr_data_b;
    logic [25:0] hdr_data_a, hdr_data_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign stall = (cyc < NCYC) ? stall_tab[cyc] : 1'b0;

    // Source memory contents modelled as addr+5 (modulo unit) and ~addr (rounding unit).
    assign mod_a   = 13'(wr_addr_a) + 13'd5;
    assign round_a = ~13'(wr_addr_a);
    assign mod_b   = 13'(wr_addr_b) + 13'd5;
    assign round_b = ~13'(wr_addr_b);

    encap_coef_sequencer #(.P(P), .AW(11), .DW(13), .SW(26), .RD_LAT(1), .HDR_ADDR(2047)) dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .deg_in(deg_in),
        .mod_in(mod_a), .round_in(round_a), .stall(stall),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .hdr_we(hdr_we_a), .hdr_addr(hdr_addr_a), .hdr_data(hdr_data_a),
        .busy(busy_a), .done(done_a)
    );

    encap_coef_sequencer #(.P(P), .AW(11), .DW(13), .SW(26), .RD_LAT(3), .HDR_ADDR(2047)) dut_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .deg_in(deg_in),
        .mod_in(mod_b), .round_in(round_b), .stall(stall),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .hdr_we(hdr_we_b), .hdr_addr(hdr_addr_b), .hdr_data(hdr_data_b),
        .busy(busy_b), .done(done_b)
    );

    // Timeline of one pass started in interval t0: header at t0+1, the k-th read at the
    // k-th unstalled cycle from t0+2, each write lat cycles after its read, done one
    // cycle after the last write, busy from the header through done.
    task automatic plan(input int inst, input int t0, input logic [1:0] m,
                        input logic [10:0] d, output int done_t);
        int lat;
        int t;
        lat = (inst == 0) ? 1 : 3;
        exp_tab[inst][t0+1].hdr_we   = 1'b1;
        exp_tab[inst][t0+1].hdr_addr = 11'd2047;
        exp_tab[inst][t0+1].hdr_data = 26'(d);
        if (m >= 2'd2) begin
            done_t = t0 + 2;
        end else begin
            t = t0 + 2;
            for (int k = 0; k < P; k++) begin
                while (stall_tab[t]) t++;
                exp_tab[inst][t].rd_en       = 1'b1;
                exp_tab[inst][t].rd_addr     = 11'(k);
                exp_tab[inst][t+lat].wr_en   = 1'b1;
                exp_tab[inst][t+lat].wr_addr = 11'(k);
                exp_tab[inst][t+lat].wr_data = (m == 2'd0) ? 13'(k + 5) : ~13'(k);
                t++;
            end
            done_t = t + lat;
        end
        for (int u = t0 + 1; u <= done_t; u++) exp_tab[inst][u].busy = 1'b1;
        exp_tab[inst][done_t].done = 1'b1;
    endtask

    task automatic truncate_from(input int t);
        for (int u = t; u < NCYC; u++) begin
            exp_tab[0][u] = '0;
            exp_tab[1][u] = '0;
        end
    endtask

    task automatic pin(input int id, input longint got, input longint want);
        pin_t p;
        p.id = id;
        p.got = got;
        p.want = want;
        pin_q.push_back(p);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pass(input int t, input logic [1:0] m, input logic [10:0] d);
        goto(t);
        start = 1'b1;
        mode = m;
        deg_in = d;
        goto(t + 1);
        start = 1'b0;
    endtask

    // Single compare process: cycle-by-cycle DUT vs model, then any queued model pins.
    always @(negedge clk) begin
        obs_t act_a, act_b;
        pin_t p;
        if (cyc >= 1 && cyc < NCYC) begin
            act_a = {rd_en_a, rd_addr_a, wr_en_a, wr_addr_a, wr_data_a, hdr_we_a,
                     hdr_addr_a, hdr_data_a, busy_a, done_a};
            act_b = {rd_en_b, rd_addr_b, wr_en_b, wr_addr_b, wr_data_b, hdr_we_b,
                     hdr_addr_b, hdr_data_b, busy_b, done_b};
            n_checks++;
            if (act_a !== exp_tab[0][cyc]) begin
                n_fail++;
                $display("FAIL cyc=%0d lat1 outputs: got rd=%b/%0d wr=%b/%0d/%0d hdr=%b/%0d/%0d busy=%b done=%b required rd=%b/%0d wr=%b/%0d/%0d hdr=%b/%0d/%0d busy=%b done=%b",
                         cyc, act_a.rd_en, act_a.rd_addr, act_a.wr_en, act_a.wr_addr, act_a.wr_data,
                         act_a.hdr_we, act_a.hdr_addr, act_a.hdr_data, act_a.busy, act_a.done,
                         exp_tab[0][cyc].rd_en, exp_tab[0][cyc].rd_addr, exp_tab[0][cyc].wr_en,
                         exp_tab[0][cyc].wr_addr, exp_tab[0][cyc].wr_data, exp_tab[0][cyc].hdr_we,
                         exp_tab[0][cyc].hdr_addr, exp_tab[0][cyc].hdr_data, exp_tab[0][cyc].busy,
                         exp_tab[0][cyc].done);
            end
            n_checks++;
            if (act_b !== exp_tab[1][cyc]) begin
                n_fail++;
                $display("FAIL cyc=%0d lat3 outputs: got rd=%b/%0d wr=%b/%0d/%0d hdr=%b/%0d/%0d busy=%b done=%b required rd=%b/%0d wr=%b/%0d/%0d hdr=%b/%0d/%0d busy=%b done=%b",
                         cyc, act_b.rd_en, act_b.rd_addr, act_b.wr_en, act_b.wr_addr, act_b.wr_data,
                         act_b.hdr_we, act_b.hdr_addr, act_b.hdr_data, act_b.busy, act_b.done,
                         exp_tab[1][cyc].rd_en, exp_tab[1][cyc].rd_addr, exp_tab[1][cyc].wr_en,
                         exp_tab[1][cyc].wr_addr, exp_tab[1][cyc].wr_data, exp_tab[1][cyc].hdr_we,
                         exp_tab[1][cyc].hdr_addr, exp_tab[1][cyc].hdr_data, exp_tab[1][cyc].busy,
                         exp_tab[1][cyc].done);
            end
        end
        while (pin_q.size() > 0) begin
            p = pin_q.pop_front();
            n_checks++;
            if (p.got != p.want) begin
                n_fail++;
                $display("FAIL model pin %0d: got %0d required %0d", p.id, p.got, p.want);
            end
        end
    end

    initial begin
        int s, da, db, da2, db2;
        for (int u = 0; u < NCYC; u++) begin
            stall_tab[u] = 1'b0;
            exp_tab[0][u] = '0;
            exp_tab[1][u] = '0;
        end
        goto(3);
        rst = 1'b0;

        // Mode 0, no stall.
        s = 10;
        plan(0, s, 2'd0, 11'd286, da);
        plan(1, s, 2'd0, 11'd286, db);
        pin(1, exp_tab[0][s+1].hdr_we, 1);
        pin(2, exp_tab[0][s+1].hdr_addr, 2047);
        pin(3, exp_tab[0][s+1].hdr_data, 286);
        pin(4, da - s, 764);
        pin(5, exp_tab[0][s+2].rd_en, 1);
        pin(6, exp_tab[0][s+763].wr_data, 765);
        pin(7, exp_tab[0][s+764].done, 1);
        start_pass(s, 2'd0, 11'd286);

        // Mode 1, round path.
        s = 810;
        plan(0, s, 2'd1, 11'd1000, da);
        plan(1, s, 2'd1, 11'd1000, db);
        pin(8, db - s, 766);
        pin(9, exp_tab[1][s+4].wr_en, 0);
        pin(10, exp_tab[1][s+5].wr_en, 1);
        pin(11, exp_tab[1][s+5].wr_data, 13'h1fff);
        start_pass(s, 2'd1, 11'd1000);

        // Mode 0 with stalls at cycles 10..14 and at the final index.
        s = 1610;
        for (int u = 10; u <= 14; u++) stall_tab[s+u] = 1'b1;
        stall_tab[s+767] = 1'b1;
        plan(0, s, 2'd0, 11'd3, da);
        plan(1, s, 2'd0, 11'd3, db);
        pin(12, da - s, 770);
        pin(13, db - s, 772);
        pin(14, exp_tab[0][s+768].rd_addr, 760);
        pin(15, exp_tab[0][s+12].wr_en, 0);
        pin(16, exp_tab[1][s+12].wr_addr, 7);
        start_pass(s, 2'd0, 11'd3);

        // Header-only pass.
        s = 2400;
        plan(0, s, 2'd2, 11'd2047, da);
        plan(1, s, 2'd2, 11'd2047, db);
        pin(17, da - s, 2);
        pin(18, exp_tab[1][s+1].hdr_data, 2047);
        start_pass(s, 2'd2, 11'd2047);

        // Reset in interval 300 of a mode-0 pass, then a fresh pass.
        s = 2420;
        plan(0, s, 2'd0, 11'd100, da);
        plan(1, s, 2'd0, 11'd100, db);
        truncate_from(s + 301);
        pin(19, exp_tab[0][s+300].wr_en, 1);
        start_pass(s, 2'd0, 11'd100);
        goto(s + 300);
        rst = 1'b1;
        goto(s + 301);
        rst = 1'b0;
        s = 2730;
        plan(0, s, 2'd1, 11'd7, da);
        plan(1, s, 2'd1, 11'd7, db);
        start_pass(s, 2'd1, 11'd7);

        // start pulsed mid-RUN and held through DONE: second pass begins after IDLE.
        s = 3510;
        plan(0, s, 2'd1, 11'd5, da);
        plan(1, s, 2'd1, 11'd5, db);
        plan(0, da + 1, 2'd1, 11'd5, da2);
        plan(1, db + 1, 2'd1, 11'd5, db2);
        pin(20, exp_tab[0][da+2].hdr_we, 1);
        pin(21, exp_tab[1][db+2].hdr_we, 1);
        start_pass(s, 2'd1, 11'd5);
        goto(s + 50);
        start = 1'b1;
        goto(s + P + 7);
        start = 1'b0;

        goto(db2 + 20);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
